// File: rtl/period_meter.sv
// Measures period and high time of an asynchronous square wave in clk_i cycles,
// averaged over 2^avg_lg_p consecutive periods, with a valid/yumi result handoff.
module period_meter #(
    parameter int width_p       = 24,
    parameter int avg_lg_p      = 2,
    parameter int sync_stages_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               sig_i,
    output logic [width_p-1:0] period_o,
    output logic [width_p-1:0] high_o,
    output logic               v_o,
    input  logic               yumi_i,
    output logic               timeout_o,
    output logic               overrun_o
);

    localparam int AW = width_p + avg_lg_p;
    localparam int KW = (avg_lg_p > 0) ? avg_lg_p : 1;
    localparam logic [KW-1:0]      K_LAST  = KW'((1 << avg_lg_p) - 1);
    localparam logic [width_p-1:0] CNT_MAX = '1;
    localparam logic [width_p-1:0] ARM_LIM = {{(width_p-1){1'b1}}, 1'b0};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] MEAS = 2'd2;

    function automatic logic [width_p-1:0] avg_trunc(input logic [AW-1:0] sum);
        logic [AW-1:0] sh;
        sh = sum >> avg_lg_p;
        return sh[width_p-1:0];
    endfunction

    logic [sync_stages_p-1:0] sync_q;
    logic                     sig_q;
    logic                     rise_q;

    logic [1:0]         state_q, state_d;
    logic [width_p-1:0] cnt_q, cnt_d;
    logic [width_p-1:0] hcnt_q, hcnt_d;
    logic [AW-1:0]      accp_q, accp_d;
    logic [AW-1:0]      acch_q, acch_d;
    logic [KW-1:0]      k_q, k_d;
    logic [AW-1:0]      sum_p, sum_h;
    logic               form;
    logic               tmo_set;

    // sig_q is the synced level delayed one cycle so it lines up with rise_q
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            sig_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[sync_stages_p-2:0], sig_i};
            sig_q  <= sync_q[sync_stages_p-1];
            rise_q <= sync_q[sync_stages_p-1] & ~sig_q;
        end
    end

    assign sum_p = accp_q + AW'(cnt_q);
    assign sum_h = acch_q + AW'(hcnt_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        accp_d  = accp_q;
        acch_d  = acch_q;
        k_d     = k_q;
        form    = 1'b0;
        tmo_set = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            hcnt_d  = '0;
            accp_d  = '0;
            acch_d  = '0;
            k_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                    accp_d  = '0;
                    acch_d  = '0;
                    k_d     = '0;
                end
                ARM: begin
                    if (rise_q) begin
                        state_d = MEAS;
                        cnt_d   = width_p'(1);
                        hcnt_d  = width_p'(sig_q);
                        accp_d  = '0;
                        acch_d  = '0;
                        k_d     = '0;
                    end else if (cnt_q == ARM_LIM) begin
                        tmo_set = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + width_p'(1);
                    end
                end
                MEAS: begin
                    if (rise_q) begin
                        cnt_d  = width_p'(1);
                        hcnt_d = width_p'(1);
                        if (k_q == K_LAST) begin
                            form   = 1'b1;
                            accp_d = '0;
                            acch_d = '0;
                            k_d    = '0;
                        end else begin
                            accp_d = sum_p;
                            acch_d = sum_h;
                            k_d    = k_q + KW'(1);
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        // No edge within the counter range: re-arm from scratch
                        tmo_set = 1'b1;
                        state_d = ARM;
                        cnt_d   = '0;
                        hcnt_d  = '0;
                        accp_d  = '0;
                        acch_d  = '0;
                        k_d     = '0;
                    end else begin
                        cnt_d  = cnt_q + width_p'(1);
                        hcnt_d = hcnt_q + width_p'(sig_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            accp_q    <= '0;
            acch_q    <= '0;
            k_q       <= '0;
            period_o  <= '0;
            high_o    <= '0;
            v_o       <= 1'b0;
            timeout_o <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            accp_q  <= accp_d;
            acch_q  <= acch_d;
            k_q     <= k_d;
            if (form) begin
                if (!v_o || yumi_i) begin
                    period_o  <= avg_trunc(sum_p);
                    high_o    <= avg_trunc(sum_h);
                    v_o       <= 1'b1;
                    timeout_o <= 1'b0;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (yumi_i) begin
                v_o <= 1'b0;
            end
            if (tmo_set) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: directed square waves, expected averages
// queued at stimulus time and checked by a monitor on each accepted result.
module tb_period_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, sig, yumi;
    logic [23:0] per, hi;
    logic        v, tmo, ovr;

    logic        en8, sig8, yumi8;
    logic [7:0]  per8, hi8;
    logic        v8, tmo8, ovr8;

    period_meter #(.width_p(24), .avg_lg_p(2), .sync_stages_p(2)) dut (
        .clk_i(clk), .reset_i(rst), .en_i(en), .sig_i(sig),
        .period_o(per), .high_o(hi), .v_o(v), .yumi_i(yumi),
        .timeout_o(tmo), .overrun_o(ovr)
    );

    period_meter #(.width_p(8), .avg_lg_p(2), .sync_stages_p(2)) dut8 (
        .clk_i(clk), .reset_i(rst), .en_i(en8), .sig_i(sig8),
        .period_o(per8), .high_o(hi8), .v_o(v8), .yumi_i(yumi8),
        .timeout_o(tmo8), .overrun_o(ovr8)
    );

    typedef struct { int p; int h; } exp_t;
    exp_t q[$];
    exp_t e;
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int h, input int l);
        sig = 1'b1; cyc(h);
        sig = 1'b0; cyc(l);
    endtask

    task automatic pulse8(input int h, input int l);
        sig8 = 1'b1; cyc(h);
        sig8 = 1'b0; cyc(l);
    endtask

    task automatic push(input int p, input int h);
        exp_t x;
        x.p = p;
        x.h = h;
        q.push_back(x);
    endtask

    task automatic idle();
        en = 1'b0; cyc(4);
        en = 1'b1; cyc(4);
    endtask

    // Monitor: every accepted result must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && v && yumi) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got period %0d high %0d, required no result", per, hi);
            end else begin
                e = q.pop_front();
                if (per !== 24'(e.p) || hi !== 24'(e.h)) begin
                    fails++;
                    $display("FAIL result: got period %0d high %0d, required period %0d high %0d",
                             per, hi, e.p, e.h);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; sig = 1'b0; yumi = 1'b1;
        en8 = 1'b0; sig8 = 1'b0; yumi8 = 1'b1;
        cyc(3);
        check("reset_v", v, 0);
        check("reset_period", per, 0);
        check("reset_high", hi, 0);
        check("reset_timeout", tmo, 0);
        check("reset_overrun", ovr, 0);
        check("reset_v8", v8, 0);
        rst = 1'b0;
        cyc(2);

        // Steady 10-cycle wave, high 4: two consecutive windows
        idle();
        repeat (4) pulse(4, 6);
        push(10, 4); pulse(4, 6);
        repeat (3) pulse(4, 6);
        push(10, 4); pulse(4, 6);
        cyc(4);

        // 20-cycle wave, high 7
        idle();
        repeat (4) pulse(7, 13);
        push(20, 7); pulse(4, 6);
        cyc(4);

        // Alternating 9/11 periods
        idle();
        repeat (2) begin pulse(3, 6); pulse(5, 6); end
        push(10, 4); pulse(4, 6);
        cyc(4);

        // 10,10,10,11: 41>>2 and 17>>2 truncate
        idle();
        repeat (3) pulse(4, 6);
        pulse(5, 6);
        push(10, 4); pulse(4, 6);
        cyc(4);

        // Held result and overrun: window 2 (period 12) must be dropped
        yumi = 1'b0;
        idle();
        repeat (4) pulse(4, 6);
        repeat (4) pulse(4, 8);
        pulse(4, 6);
        check("hold_v", v, 1);
        check("hold_period", per, 10);
        check("hold_high", hi, 4);
        check("overrun_set", ovr, 1);
        push(10, 4);
        yumi = 1'b1; cyc(1);
        yumi = 1'b0;
        check("yumi_drops_v", v, 0);
        repeat (3) pulse(6, 8);
        pulse(4, 6);
        check("reassert_v", v, 1);
        check("reassert_period", per, 13);
        check("reassert_high", hi, 5);
        push(13, 5);
        yumi = 1'b1; cyc(2);
        check("overrun_sticky", ovr, 1);

        // Reset mid-window, then a full fresh window is required
        idle();
        repeat (3) pulse(4, 6);
        rst = 1'b1; cyc(1);
        check("midreset_v", v, 0);
        check("midreset_period", per, 0);
        check("midreset_high", hi, 0);
        check("midreset_overrun", ovr, 0);
        check("midreset_timeout", tmo, 0);
        rst = 1'b0;
        repeat (4) pulse(4, 6);
        push(10, 4); pulse(4, 6);
        cyc(4);

        // Enable drop mid-window discards the partial window
        idle();
        repeat (2) pulse(4, 6);
        pulse(4, 3);
        en = 1'b0; cyc(3);
        en = 1'b1; cyc(3);
        repeat (4) pulse(4, 6);
        push(10, 4); pulse(4, 6);
        cyc(4);
        en = 1'b0;

        // Timeout on the 8-bit instance
        en8 = 1'b1; yumi8 = 1'b0; cyc(4);
        pulse8(4, 6);
        n = 0;
        while (!tmo8 && n < 400) begin cyc(1); n++; end
        check("timeout8_set", tmo8, 1);
        check("timeout8_latency_in_range", (n >= 245 && n <= 255), 1);
        check("timeout8_no_v", v8, 0);
        repeat (4) pulse8(8, 12);
        check("timeout8_held", tmo8, 1);
        pulse8(8, 12);
        check("resume8_v", v8, 1);
        check("resume8_period", per8, 20);
        check("resume8_high", hi8, 8);
        check("resume8_timeout_cleared", tmo8, 0);
        check("resume8_no_overrun", ovr8, 0);

        n = 0;
        while (q.size() != 0 && n < 100) begin cyc(1); n++; end
        check("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
